// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline registers
// Resolves load-use, branch, fetch-wait and dmem-wait hazards; drains and freezes on context switch.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int DRAIN_DEPTH = 4,
  parameter int WAIT_W      = 8,
  parameter int MAX_WAIT    = 200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  ex_d_mem_r,
  input  logic [REG_ADDR_W-1:0] ex_write_address,
  input  logic                  ex_branch_taken,
  input  logic                  mem_d_mem_r,
  input  logic                  mem_d_mem_w,
  input  logic                  d_mem_busy,
  input  logic                  i_mem_busy,
  input  logic                  ctx_switch_req,
  input  logic                  ctx_switch_release,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_en,
  output logic                  id_ex_flush,
  output logic                  ex_mem_en,
  output logic                  mem_wb_flush,
  output logic                  ctx_switch_ack,
  output logic                  dmem_timeout,
  output logic [31:0]           stall_count
);

  localparam int DCNT_W = (DRAIN_DEPTH > 1) ? $clog2(DRAIN_DEPTH) : 1;
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_DEPTH - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [DCNT_W-1:0]   drain_cnt;
  logic [DCNT_W-1:0]   drain_cnt_next;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                dstall;
  logic                luse;
  logic                rs1_hit;
  logic                rs2_hit;

  assign dstall  = (mem_d_mem_r | mem_d_mem_w) & d_mem_busy;
  assign rs1_hit = id_rs1_used & (id_rs1_addr == ex_write_address);
  assign rs2_hit = id_rs2_used & (id_rs2_addr == ex_write_address);
  assign luse    = ex_d_mem_r & (ex_write_address != '0) & (rs1_hit | rs2_hit);

  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    pc_en          = 1'b1;
    if_id_en       = 1'b1;
    id_ex_en       = 1'b1;
    ex_mem_en      = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    mem_wb_flush   = 1'b0;
    ctx_switch_ack = 1'b0;

    if (reset) begin
      pc_en          = 1'b0;
      if_id_en       = 1'b0;
      id_ex_en       = 1'b0;
      ex_mem_en      = 1'b0;
      state_next     = ST_RUN;
      drain_cnt_next = '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (dstall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
          end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (luse) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end else if (i_mem_busy) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
          end
          // A pending dmem access must finish before the drain can start.
          if (ctx_switch_req && !dstall) begin
            state_next     = ST_DRAIN;
            drain_cnt_next = '0;
          end
        end

        ST_DRAIN: begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
          if (dstall) begin
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            if_id_flush  = 1'b0;
            mem_wb_flush = 1'b1;
          end else if (ex_branch_taken) begin
            // Capture the redirect target so it survives the freeze; drain starts over.
            pc_en          = 1'b1;
            id_ex_flush    = 1'b1;
            drain_cnt_next = '0;
          end else if (luse) begin
            if_id_en    = 1'b0;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b1;
          end else if (drain_cnt == DRAIN_LAST) begin
            state_next     = ST_HALTED;
            drain_cnt_next = '0;
          end else begin
            drain_cnt_next = drain_cnt + DCNT_W'(1);
          end
          if (!ctx_switch_req) begin
            state_next     = ST_RUN;
            drain_cnt_next = '0;
          end
        end

        ST_HALTED: begin
          pc_en          = 1'b0;
          if_id_en       = 1'b0;
          id_ex_en       = 1'b0;
          ex_mem_en      = 1'b0;
          ctx_switch_ack = 1'b1;
          if (ctx_switch_release) begin
            state_next = ST_RUN;
          end
        end

        default: begin
          state_next     = ST_RUN;
          drain_cnt_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_RUN;
      drain_cnt    <= '0;
      wait_cnt     <= '0;
      dmem_timeout <= 1'b0;
      stall_count  <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
      if (dstall) begin
        if (wait_cnt != '1) begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        if (wait_cnt == WAIT_LIMIT) begin
          dmem_timeout <= 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
      if (state == ST_RUN && !pc_en && stall_count != 32'hFFFF_FFFF) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Detects load-use hazards, taken-branch redirects, instruction-fetch wait and data-memory wait, and drives per-stage enable/flush.
- Also drains the pipeline on an OS context-switch request before cache switching, then holds it frozen until release.

Parameters:
REG_ADDR_W, 5, register address width
DRAIN_DEPTH, 4, bubble-advancing cycles needed to empty the pipeline
WAIT_W, 8, width of data-memory wait counter
MAX_WAIT, 200, dmem stall cycles after which dmem_timeout sets

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
id_rs1_addr  input  REG_ADDR_W  rs1 of instruction in ID
id_rs2_addr  input  REG_ADDR_W  rs2 of instruction in ID
id_rs1_used  input  1  ID instruction reads rs1
id_rs2_used  input  1  ID instruction reads rs2
ex_d_mem_r  input  1  instruction in EX is a load
ex_write_address  input  REG_ADDR_W  rd of instruction in EX
ex_branch_taken  input  1  EX resolved a taken branch/jump
mem_d_mem_r  input  1  EX/MEM register holds a load
mem_d_mem_w  input  1  EX/MEM register holds a store
d_mem_busy  input  1  data memory/cache access not yet complete
i_mem_busy  input  1  instruction fetch not yet complete
ctx_switch_req  input  1  level request to drain and freeze
ctx_switch_release  input  1  pulse: resume after freeze
pc_en  output  1  PC update enable
if_id_en  output  1  IF/ID load enable
if_id_flush  output  1  IF/ID loads bubble
id_ex_en  output  1  ID/EX load enable
id_ex_flush  output  1  ID/EX loads bubble
ex_mem_en  output  1  EX/MEM load enable
mem_wb_flush  output  1  MEM/WB loads bubble
ctx_switch_ack  output  1  pipeline empty and frozen
dmem_timeout  output  1  sticky: dmem stall exceeded MAX_WAIT
stall_count  output  32  saturating count of cycles with pc_en=0 in RUN

Behaviour:
- FSM states RUN, DRAIN, HALTED (registered).
- Enables and flushes are combinational from state and inputs, so they act in the same cycle.
- Reset: state RUN, drain_cnt 0, wait_cnt 0, dmem_timeout 0, stall_count 0. While reset=1, all *_en=0, all flushes=0, ack=0.
- Definitions:
  - dstall = (mem_d_mem_r | mem_d_mem_w) & d_mem_busy
  - luse = ex_d_mem_r & ex_write_address!=0 & ((id_rs1_used & id_rs1_addr==ex_write_address) | (id_rs2_used & id_rs2_addr==ex_write_address))
- Default outputs: all *_en=1, flushes=0.
- RUN priority, highest first:
  1. dstall: pc_en, if_id_en, id_ex_en, ex_mem_en = 0; mem_wb_flush=1.
  2. ex_branch_taken: if_id_flush=1, id_ex_flush=1. Branch overrides load-use and i_mem_busy.
  3. luse: pc_en=0, if_id_en=0, id_ex_flush=1. Exactly one bubble per hazard.
  4. i_mem_busy: pc_en=0, if_id_flush=1.
- wait_cnt: increments each dstall cycle, saturating at all-ones; clears on a non-dstall cycle. dmem_timeout sets when wait_cnt==MAX_WAIT during dstall and stays set until reset. Stalling continues regardless.
- RUN -> DRAIN: ctx_switch_req=1 and not dstall; drain_cnt cleared.
- DRAIN:
  - pc_en=0, if_id_flush=1, except:
    - dstall: as RUN rule 1, drain_cnt holds.
    - ex_branch_taken: pc_en=1 so the redirect target is captured; if_id_flush=1, id_ex_flush=1; drain_cnt cleared.
    - luse: if_id_en=0, if_id_flush=0, id_ex_flush=1, drain_cnt holds.
  - Otherwise drain_cnt increments; at DRAIN_DEPTH-1 increment go to HALTED.
  - ctx_switch_req dropping in DRAIN returns to RUN next cycle; drain_cnt cleared.
- HALTED: all *_en=0, flushes=0, ctx_switch_ack=1.
  - ctx_switch_release=1 -> RUN next cycle; ack low from that cycle.
  - ctx_switch_req is ignored in HALTED.
- stall_count: +1 each RUN cycle with pc_en=0; saturates at 0xFFFFFFFF.
- Reset mid-drain or mid-HALTED returns to RUN with ack=0 next cycle.

Test Plan:
- Load x5 in EX, ID add reads rs1=x5 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables 1; stall_count=1.
- Load x0 in EX, ID reads x0 -> no stall (all en=1, flushes 0).
- Branch taken and luse in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_en=1.
- Store in MEM, d_mem_busy held 3 cycles -> pc/if_id/id_ex/ex_mem en=0 and mem_wb_flush=1 for exactly 3 cycles; held 201 cycles -> dmem_timeout=1 from cycle 201, still 1 after busy clears.
- ctx_switch_req with no hazards -> ack=1 after 4 DRAIN cycles; release pulse -> RUN, ack=0 next cycle, pc_en=1.
- Taken branch during DRAIN cycle 2 -> pc_en=1 that cycle, drain restarts, ack after 4 further clean cycles.
